delay_line_hs: RTL and testbench
================================

Name: delay_line_hs

Overview:
- Parametrised successor to the single-stage vector delay element used in the DSP datapath.
- Delays paired vector operands (a, b) by a configurable number of stages, DEPTH.
- Adds a valid/ready handshake with bubble-collapsing backpressure, a synchronous flush and an occupancy count.
- Sits between vector DSP stages that need operand alignment under stall conditions.

Parameters:
- REG_WIDTH, 16: bit width of each vector element.
- VECTOR, 8: number of elements per operand vector.
- DEPTH, 4: number of pipeline stages; legal range DEPTH >= 1. DEPTH=0 is illegal and must cause an elaboration error.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all stages.
- in_valid  input  1  input vector pair present.
- in_ready  output  1  block accepts the input this cycle.
- a_n_1  input  [REG_WIDTH-1:0] x [VECTOR-1:0]  operand A in.
- b_n_1  input  [REG_WIDTH-1:0] x [VECTOR-1:0]  operand B in.
- out_valid  output  1  output vector pair present.
- out_ready  input  1  downstream accepts the output.
- a_n  output  [REG_WIDTH-1:0] x [VECTOR-1:0]  operand A out (last stage).
- b_n  output  [REG_WIDTH-1:0] x [VECTOR-1:0]  operand B out (last stage).
- count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Storage: stages s[0..DEPTH-1], each holding a valid bit v[i] plus A/B vectors. Output ports are driven from s[DEPTH-1]; out_valid = v[DEPTH-1].
- Load condition (combinational chain from the output end):
  - ld[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - ld[i] = !v[i] | ld[i+1].
  - in_ready = ld[0] & !flush & !rst.
- Stage update on each posedge:
  - If ld[i], s[i] takes s[i-1]. For i=0, the source is the input: valid = in_valid & in_ready.
  - If !ld[i], s[i] holds.
  - An empty upstream stage propagates as a bubble (v=0).
- Transfers: input is accepted when in_valid & in_ready; output is consumed when out_valid & out_ready.
- Latency and throughput:
  - A beat accepted at edge t raises out_valid after edge t+DEPTH-1, i.e. DEPTH cycles, with no stall.
  - Throughput is 1 beat/cycle while out_ready=1.
- Backpressure:
  - With out_ready=0, bubbles collapse forward; up to DEPTH beats are stored.
  - in_ready falls only when all stages are valid and out_ready=0.
  - Simultaneous accept and consume on a full line is allowed, because in_ready = 1 when out_ready = 1.
- Stall hold: a_n, b_n and out_valid must remain stable while out_valid=1 and out_ready=0.
- Ordering: beats are never reordered, duplicated or dropped except by flush/rst.
- count:
  - Registered; equals popcount of v[] after each edge.
  - Updates +1 on accept only, -1 on consume only, unchanged on both or neither.
  - Range is 0..DEPTH.
- Flush: all v[i] = 0 and count = 0 at the next edge. An input presented in the flush cycle is discarded; in_ready = 0 that cycle.
- Reset:
  - rst has priority over flush; same clearing effect.
  - Values after reset: v[]=0, out_valid=0, count=0, in_ready=0 during rst and 1 in the first cycle after.
  - Reset mid-stall discards all stored beats.
- Data path: data registers are not reset (see optional feature). Elements pass unmodified; no arithmetic.

Optional Feature:
- Macro: DELAY_LINE_ZERO_INVALID_EN.
- Defined:
  - Stage data registers clear to 0 on rst/flush.
  - A stage loading a bubble writes 0.
  - a_n/b_n read all-zero whenever out_valid=0.
- Undefined:
  - Data registers have no reset and load unconditionally on ld[i].
  - a_n/b_n are don't-care while out_valid=0.
- Handshake timing is identical in both builds.

Test Plan (all scenarios use DEPTH=4, VECTOR=8, REG_WIDTH=16):
- Streaming:
  - Stimulus: rst 2 cycles, then in_valid=1 and out_ready=1 for 10 cycles, element k of beat n = 16'h0100*n+k.
  - Required: out_valid first rises 4 cycles after the first accept; beats 0..9 emerge in order, one per cycle; count steady at 4.
- Fill under stall:
  - Stimulus: out_ready=0, push beats 1..6.
  - Required: beats 1..4 accepted; in_ready=0 from the cycle after the 4th accept; count=4; a_n[0]=16'h0100 held stable.
  - Then: out_ready=1 → beats 1..4 drained in order; beats 5,6 accepted as slots free.
- Bubble collapse:
  - Stimulus: push beats A and B with a 2-cycle gap while out_ready=0.
  - Required: both stored, count=2, in_ready stays 1.
  - Then: out_ready=1 → A and B emerge on consecutive cycles.
- Flush:
  - Stimulus: with 3 beats stored, flush=1 and in_valid=1 for 1 cycle.
  - Required: in_ready=0 that cycle; next cycle count=0, out_valid=0; the flushed input never appears.
- Reset mid-operation:
  - Stimulus: rst asserted while full and stalled.
  - Required: out_valid=0 and count=0 after the edge; normal operation resumes the cycle after rst deasserts.
- Zero-invalid:
  - Build: with DELAY_LINE_ZERO_INVALID_EN.
  - Required: a_n=b_n=0 after reset and in every bubble cycle.
  - Build: without the macro → only out_valid is checked in those cycles.

Source files
------------

// File: rtl/delay_line_hs.sv
// Multi-stage paired-vector delay line with valid/ready handshake, bubble collapse,
// synchronous flush and occupancy count. Optional macro: DELAY_LINE_ZERO_INVALID_EN.

module delay_line_hs_stage #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic         src_v,
  input  logic [W-1:0] src_d,
  output logic         vld,
  output logic [W-1:0] dat
);
  always_ff @(posedge clk)
    if (clr)     vld <= 1'b0;
    else if (ld) vld <= src_v;

`ifdef DELAY_LINE_ZERO_INVALID_EN
  // Data tracks the valid bit: a stage holding a bubble always reads zero.
  always_ff @(posedge clk)
    if (clr)     dat <= '0;
    else if (ld) dat <= src_v ? src_d : '0;
`else
  always_ff @(posedge clk)
    if (ld) dat <= src_d;
`endif
endmodule

module delay_line_hs #(
  parameter int REG_WIDTH = 16,
  parameter int VECTOR    = 8,
  parameter int DEPTH     = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0]   a_n_1,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0]   b_n_1,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [VECTOR-1:0][REG_WIDTH-1:0]   a_n,
  output logic [VECTOR-1:0][REG_WIDTH-1:0]   b_n,
  output logic [$clog2(DEPTH+1)-1:0]         count
);
  if (DEPTH < 1) begin : g_depth_chk
    $error("delay_line_hs: DEPTH must be >= 1");
  end

  localparam int W  = 2 * VECTOR * REG_WIDTH;
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [VECTOR-1:0][REG_WIDTH-1:0] a;
    logic [VECTOR-1:0][REG_WIDTH-1:0] b;
  } beat_t;

  logic [DEPTH-1:0]        vld_pipe;
  logic [DEPTH-1:0]        ld;
  logic [DEPTH-1:0]        src_v;
  logic [DEPTH-1:0][W-1:0] src_d;
  logic [DEPTH-1:0][W-1:0] stg_dat;
  beat_t                   in_beat, out_beat;
  logic                    acc_in, cons, clr;

  // A stage may load if it is empty or everything downstream of it moves.
  always_comb begin
    logic open;
    open = out_ready;
    ld   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      open  = open | ~vld_pipe[i];
      ld[i] = open;
    end
  end

  assign in_ready  = ld[0] & ~flush & ~rst;
  assign acc_in    = in_valid & in_ready;
  assign cons      = out_valid & out_ready;
  assign clr       = rst | flush;
  assign in_beat.a = a_n_1;
  assign in_beat.b = b_n_1;

  always_comb begin
    src_v    = '0;
    src_d    = '0;
    src_v[0] = acc_in;
    src_d[0] = in_beat;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = vld_pipe[i-1];
      src_d[i] = stg_dat[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    delay_line_hs_stage #(.W(W)) u_stg (
      .clk  (clk),
      .clr  (clr),
      .ld   (ld[i]),
      .src_v(src_v[i]),
      .src_d(src_d[i]),
      .vld  (vld_pipe[i]),
      .dat  (stg_dat[i])
    );
  end

  assign out_beat  = beat_t'(stg_dat[DEPTH-1]);
  assign out_valid = vld_pipe[DEPTH-1];
  assign a_n       = out_beat.a;
  assign b_n       = out_beat.b;

  always_ff @(posedge clk)
    if (clr)                 count <= '0;
    else if (acc_in && !cons) count <= count + CW'(1);
    else if (!acc_in && cons) count <= count - CW'(1);
endmodule

// File: tb/tb_delay_line_hs.sv
// Directed self-checking bench for delay_line_hs at DEPTH=4, VECTOR=8, REG_WIDTH=16.
module tb_delay_line_hs;
  typedef logic [7:0][15:0] vec_t;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_ready, out_valid, out_ready;
  vec_t       a_n_1, b_n_1, a_n, b_n;
  logic [2:0] count;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  delay_line_hs #(.REG_WIDTH(16), .VECTOR(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .a_n_1(a_n_1), .b_n_1(b_n_1),
    .out_valid(out_valid), .out_ready(out_ready), .a_n(a_n), .b_n(b_n),
    .count(count)
  );

  function automatic vec_t mka(int n);
    vec_t v;
    for (int k = 0; k < 8; k++) v[k] = 16'(32'h0100 * n + k);
    return v;
  endfunction

  function automatic vec_t mkb(int n);
    return ~mka(n);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input int n);
    in_valid = v;
    a_n_1    = mka(n);
    b_n_1    = mkb(n);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; drive(1'b0, 0);
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready_during: got %b exp 0", in_ready); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d exp 0", count); end
    tick();
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready_after: got %b exp 1", in_ready); end
`ifdef DELAY_LINE_ZERO_INVALID_EN
    tests++; if (a_n !== '0 || b_n !== '0) begin fails++; $display("FAIL reset_zero_data: got %h/%h exp 0", a_n, b_n); end
`endif
    tick();
  endtask

  task automatic test_streaming();
    int exp_cnt;
    out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      drive(c < 10, c);
      #1;
      exp_cnt = ((c < 10) ? c : 10) - (((c < 14) ? c : 14) > 4 ? ((c < 14) ? c : 14) - 4 : 0);
      tests++; if (out_valid !== (c >= 4 && c < 14)) begin fails++; $display("FAIL stream_out_valid c%0d: got %b exp %b", c, out_valid, (c >= 4 && c < 14)); end
      tests++; if (count !== 3'(exp_cnt)) begin fails++; $display("FAIL stream_count c%0d: got %0d exp %0d", c, count, exp_cnt); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready c%0d: got %b exp 1", c, in_ready); end
      if (c >= 4 && c < 14) begin
        tests++; if (a_n !== mka(c-4) || b_n !== mkb(c-4)) begin fails++; $display("FAIL stream_data c%0d: got %h exp %h", c, a_n, mka(c-4)); end
      end
`ifdef DELAY_LINE_ZERO_INVALID_EN
      else begin
        tests++; if (a_n !== '0 || b_n !== '0) begin fails++; $display("FAIL stream_bubble_zero c%0d: got %h/%h exp 0", c, a_n, b_n); end
      end
`endif
      tick();
    end
  endtask

  task automatic test_fill_stall();
    int nxt = 1;
    int exp_out = 1;
    int cnt_exp [7] = '{4, 4, 4, 3, 2, 1, 0};
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, nxt);
      #1;
      tests++; if (in_ready !== (c < 4)) begin fails++; $display("FAIL fill_in_ready c%0d: got %b exp %b", c, in_ready, (c < 4)); end
      tests++; if (count !== 3'((c < 4) ? c : 4)) begin fails++; $display("FAIL fill_count c%0d: got %0d exp %0d", c, count, (c < 4) ? c : 4); end
      if (c >= 4) begin
        tests++; if (out_valid !== 1'b1 || a_n[0] !== 16'h0100 || a_n !== mka(1) || b_n !== mkb(1)) begin fails++; $display("FAIL fill_hold c%0d: got v=%b a=%h exp v=1 a=%h", c, out_valid, a_n, mka(1)); end
      end
      if (c < 4) nxt++;
      tick();
    end
    out_ready = 1'b1;
    for (int c = 7; c < 14; c++) begin
      drive(nxt <= 6, nxt);
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL drain_in_ready c%0d: got %b exp 1", c, in_ready); end
      tests++; if (out_valid !== (c <= 12)) begin fails++; $display("FAIL drain_out_valid c%0d: got %b exp %b", c, out_valid, (c <= 12)); end
      tests++; if (count !== 3'(cnt_exp[c-7])) begin fails++; $display("FAIL drain_count c%0d: got %0d exp %0d", c, count, cnt_exp[c-7]); end
      if (c <= 12) begin
        tests++; if (a_n !== mka(exp_out) || b_n !== mkb(exp_out)) begin fails++; $display("FAIL drain_data c%0d: got %h exp %h", c, a_n, mka(exp_out)); end
        exp_out++;
      end
      if (nxt <= 6) nxt++;
      tick();
    end
  endtask

  task automatic test_bubble_collapse();
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(c == 0 || c == 3, (c == 0) ? 20 : 21);
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bubble_in_ready c%0d: got %b exp 1", c, in_ready); end
      if (c >= 4) begin
        tests++; if (count !== 3'd2) begin fails++; $display("FAIL bubble_count c%0d: got %0d exp 2", c, count); end
        tests++; if (out_valid !== 1'b1 || a_n !== mka(20)) begin fails++; $display("FAIL bubble_head c%0d: got v=%b a=%h exp v=1 a=%h", c, out_valid, a_n, mka(20)); end
      end
      tick();
    end
    out_ready = 1'b1; drive(1'b0, 0);
    for (int c = 6; c < 9; c++) begin
      #1;
      tests++; if (out_valid !== (c < 8)) begin fails++; $display("FAIL bubble_drain_valid c%0d: got %b exp %b", c, out_valid, (c < 8)); end
      if (c < 8) begin
        tests++; if (a_n !== mka(14 + c) || b_n !== mkb(14 + c)) begin fails++; $display("FAIL bubble_drain_data c%0d: got %h exp %h", c, a_n, mka(14 + c)); end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin drive(1'b1, 30 + c); tick(); end
    flush = 1'b1; drive(1'b1, 33);
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready: got %b exp 0", in_ready); end
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL flush_pre_count: got %0d exp 3", count); end
    tick();
    flush = 1'b0; out_ready = 1'b1; drive(1'b0, 0);
    #1;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL flush_count: got %0d exp 0", count); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready_after: got %b exp 1", in_ready); end
    for (int c = 0; c < 5; c++) begin
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_output c%0d: got %b exp 0", c, out_valid); end
`ifdef DELAY_LINE_ZERO_INVALID_EN
      tests++; if (a_n !== '0 || b_n !== '0) begin fails++; $display("FAIL flush_zero c%0d: got %h/%h exp 0", c, a_n, b_n); end
`endif
      tick(); #1;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin drive(1'b1, 40 + c); tick(); end
    drive(1'b0, 0);
    #1;
    tests++; if (in_ready !== 1'b0 || count !== 3'd4 || out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_full: got rdy=%b cnt=%0d v=%b exp 0/4/1", in_ready, count, out_valid); end
    tick();
    rst = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_in_ready: got %b exp 0", in_ready); end
    tick();
    rst = 1'b0; out_ready = 1'b1; drive(1'b1, 44);
    #1;
    tests++; if (out_valid !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL rstmid_cleared: got v=%b cnt=%0d exp 0/0", out_valid, count); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_resume_ready: got %b exp 1", in_ready); end
`ifdef DELAY_LINE_ZERO_INVALID_EN
    tests++; if (a_n !== '0 || b_n !== '0) begin fails++; $display("FAIL rstmid_zero: got %h/%h exp 0", a_n, b_n); end
`endif
    tick();
    drive(1'b0, 0);
    for (int c = 1; c < 6; c++) begin
      #1;
      tests++; if (out_valid !== (c == 4)) begin fails++; $display("FAIL rstmid_resume_valid c%0d: got %b exp %b", c, out_valid, (c == 4)); end
      if (c == 4) begin
        tests++; if (a_n !== mka(44) || b_n !== mkb(44)) begin fails++; $display("FAIL rstmid_resume_data: got %h exp %h", a_n, mka(44)); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_fill_stall();
    test_bubble_collapse();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
